// File: rtl/feed_scheduler.sv
// Feed-time scheduler: matches the wall-clock time against programmable slots and
// drives a timed dispenser pulse, followed by a cooldown, with a one-deep request queue.
module feed_scheduler #(
  parameter int NUM_SLOTS       = 4,
  parameter int SLOT_W          = 2,
  parameter int DISPENSE_CYCLES = 50000000,
  parameter int COOLDOWN_CYCLES = 250000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        hour,
  input  logic [7:0]        minute,
  input  logic [7:0]        second,
  input  logic              ampm,
  input  logic [SLOT_W-1:0] cfgSlot,
  input  logic [7:0]        cfgData,
  input  logic              cfgWriteHour,
  input  logic              cfgWriteMin,
  input  logic              cfgWriteAmpm,
  input  logic              cfgWriteEnable,
  input  logic              manualFeed,
  output logic              motorOn,
  output logic              busy,
  output logic [15:0]       feedCount,
  output logic [SLOT_W-1:0] lastSlot,
  output logic              lastManual,
  output logic              overrun
);
  localparam int MAX_CYC = (DISPENSE_CYCLES > COOLDOWN_CYCLES) ? DISPENSE_CYCLES : COOLDOWN_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] DISP_LAST = CNT_W'(DISPENSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DISPENSE, S_COOLDOWN} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pending_q, pending_d;
  logic              pend_manual_q, pend_manual_d;
  logic [SLOT_W-1:0] pend_slot_q, pend_slot_d;
  logic              motor_on_q, motor_on_d;
  logic [15:0]       feed_count_q, feed_count_d;
  logic [SLOT_W-1:0] last_slot_q, last_slot_d;
  logic              last_manual_q, last_manual_d;
  logic              overrun_q, overrun_d;
  logic [7:0]        prev_minute_q, prev_minute_d;
  logic              manual_prev_q, manual_prev_d;

  logic [3:0] slot_hour_q [NUM_SLOTS];
  logic [3:0] slot_hour_d [NUM_SLOTS];
  logic [5:0] slot_min_q  [NUM_SLOTS];
  logic [5:0] slot_min_d  [NUM_SLOTS];
  logic       slot_ampm_q [NUM_SLOTS];
  logic       slot_ampm_d [NUM_SLOTS];
  logic       slot_en_q   [NUM_SLOTS];
  logic       slot_en_d   [NUM_SLOTS];

  logic              match_any;
  logic [SLOT_W-1:0] match_idx;
  logic              sched_evt;
  logic              manual_evt;
  logic              trigger;
  logic              cool_done;

  // Scan from the top down so the lowest matching slot wins; uses registered (pre-write) slot values.
  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (slot_en_q[i] && (hour == {4'd0, slot_hour_q[i]}) &&
          (minute == {2'd0, slot_min_q[i]}) && (ampm == slot_ampm_q[i])) begin
        match_any = 1'b1;
        match_idx = SLOT_W'(i);
      end
    end
  end

  assign sched_evt  = (minute != prev_minute_q) && (second == 8'd0) && match_any;
  assign manual_evt = manualFeed && !manual_prev_q;
  assign trigger    = sched_evt || manual_evt;

  // NOTE: every *_d gets a default from its *_q first, so no path leaves a value unassigned (no latches).
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pending_d     = pending_q;
    pend_manual_d = pend_manual_q;
    pend_slot_d   = pend_slot_q;
    feed_count_d  = feed_count_q;
    last_slot_d   = last_slot_q;
    last_manual_d = last_manual_q;
    overrun_d     = overrun_q;
    prev_minute_d = minute;
    manual_prev_d = manualFeed;
    slot_hour_d   = slot_hour_q;
    slot_min_d    = slot_min_q;
    slot_ampm_d   = slot_ampm_q;
    slot_en_d     = slot_en_q;
    cool_done     = 1'b0;

    // Indices at or above NUM_SLOTS never compare equal, so such writes fall away.
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (cfgSlot == SLOT_W'(i)) begin
        if (cfgWriteHour && (cfgData >= 8'd1) && (cfgData <= 8'd12)) slot_hour_d[i] = cfgData[3:0];
        if (cfgWriteMin && (cfgData <= 8'd59)) slot_min_d[i] = cfgData[5:0];
        if (cfgWriteAmpm)   slot_ampm_d[i] = cfgData[0];
        if (cfgWriteEnable) slot_en_d[i]   = cfgData[0];
      end
    end

    case (state_q)
      S_DISPENSE: begin
        if (cnt_q == DISP_LAST) begin
          state_d      = S_COOLDOWN;
          cnt_d        = '0;
          feed_count_d = feed_count_q + 16'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_COOLDOWN: begin
        if (cnt_q == COOL_LAST) begin
          cool_done = 1'b1;
          cnt_d     = '0;
          if (pending_q) begin
            state_d       = S_DISPENSE;
            pending_d     = 1'b0;
            last_manual_d = pend_manual_q;
            if (!pend_manual_q) last_slot_d = pend_slot_q;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase

    // A trigger landing on the final cooldown edge with nothing queued starts straight away.
    if (trigger) begin
      if ((state_q == S_IDLE) || (cool_done && !pending_q)) begin
        state_d       = S_DISPENSE;
        cnt_d         = '0;
        last_manual_d = !sched_evt;
        if (sched_evt) last_slot_d = match_idx;
      end else if (!pending_d) begin
        pending_d     = 1'b1;
        pend_manual_d = !sched_evt;
        pend_slot_d   = match_idx;
      end else begin
        overrun_d = 1'b1;
      end
    end

    motor_on_d = (state_d == S_DISPENSE);
  end

  // NOTE: sequential state uses non-blocking assignments only; the always_comb above is blocking.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      pending_q     <= 1'b0;
      pend_manual_q <= 1'b0;
      pend_slot_q   <= '0;
      motor_on_q    <= 1'b0;
      feed_count_q  <= '0;
      last_slot_q   <= '0;
      last_manual_q <= 1'b0;
      overrun_q     <= 1'b0;
      prev_minute_q <= minute;
      manual_prev_q <= 1'b1;
      // NOTE: the slot table is a small register file that must come up at a known schedule, so it is reset.
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_hour_q[i] <= 4'd12;
        slot_min_q[i]  <= 6'd0;
        slot_ampm_q[i] <= 1'b0;
        slot_en_q[i]   <= 1'b0;
      end
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pending_q     <= pending_d;
      pend_manual_q <= pend_manual_d;
      pend_slot_q   <= pend_slot_d;
      motor_on_q    <= motor_on_d;
      feed_count_q  <= feed_count_d;
      last_slot_q   <= last_slot_d;
      last_manual_q <= last_manual_d;
      overrun_q     <= overrun_d;
      prev_minute_q <= prev_minute_d;
      manual_prev_q <= manual_prev_d;
      slot_hour_q   <= slot_hour_d;
      slot_min_q    <= slot_min_d;
      slot_ampm_q   <= slot_ampm_d;
      slot_en_q     <= slot_en_d;
    end
  end

  assign motorOn    = motor_on_q;
  assign busy       = (state_q != S_IDLE);
  assign feedCount  = feed_count_q;
  assign lastSlot   = last_slot_q;
  assign lastManual = last_manual_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_feed_scheduler.sv
// Bench for feed_scheduler: directed scenarios plus random traffic, all checked every
// cycle against a timeline model (pulse start edge, queued request, sticky drop flag).
module tb_feed_scheduler;
  localparam int NS = 3;
  localparam int SW = 2;
  localparam int D  = 4;
  localparam int C  = 3;
  localparam logic [3:0] W_HR = 4'b1000, W_MN = 4'b0100, W_AP = 4'b0010, W_EN = 4'b0001;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    hour = 8'd7, minute = 8'd29, second = 8'd59;
  logic          ampm = 1'b1;
  logic [SW-1:0] cfgSlot = '0;
  logic [7:0]    cfgData = 8'd0;
  logic          cfgWriteHour = 1'b0, cfgWriteMin = 1'b0, cfgWriteAmpm = 1'b0, cfgWriteEnable = 1'b0;
  logic          manualFeed = 1'b0;
  logic          motorOn, busy, lastManual, overrun;
  logic [15:0]   feedCount;
  logic [SW-1:0] lastSlot;

  feed_scheduler #(.NUM_SLOTS(NS), .SLOT_W(SW), .DISPENSE_CYCLES(D), .COOLDOWN_CYCLES(C)) dut (
    .clk(clk), .reset(reset), .hour(hour), .minute(minute), .second(second), .ampm(ampm),
    .cfgSlot(cfgSlot), .cfgData(cfgData), .cfgWriteHour(cfgWriteHour), .cfgWriteMin(cfgWriteMin),
    .cfgWriteAmpm(cfgWriteAmpm), .cfgWriteEnable(cfgWriteEnable), .manualFeed(manualFeed),
    .motorOn(motorOn), .busy(busy), .feedCount(feedCount), .lastSlot(lastSlot),
    .lastManual(lastManual), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int n = 0;

  // Reference model: slot table plus the edge index at which the current pulse started.
  int m_hr [NS];
  int m_mn [NS];
  bit m_ap [NS];
  bit m_en [NS];
  int m_start = -1000;
  bit m_pend = 0, m_pend_man = 0, m_last_man = 0, m_ovr = 0, m_prev_man = 1;
  int m_pend_slot = 0, m_count = 0, m_last_slot = 0, m_prev_min = 0;
  bit e_motor = 0, e_busy = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, n);
  endtask

  task automatic model_edge();
    bit sched, man, busy_b, free;
    int ms, age;
    if (reset) begin
      for (int i = 0; i < NS; i++) begin
        m_hr[i] = 12; m_mn[i] = 0; m_ap[i] = 0; m_en[i] = 0;
      end
      m_start = -1000; m_pend = 0; m_pend_man = 0; m_pend_slot = 0;
      m_count = 0; m_last_slot = 0; m_last_man = 0; m_ovr = 0;
      m_prev_min = int'(minute); m_prev_man = 1;
    end else begin
      sched = 0; ms = 0;
      if (int'(minute) != m_prev_min && second == 8'd0)
        for (int i = 0; i < NS; i++)
          if (!sched && m_en[i] && int'(hour) == m_hr[i] && int'(minute) == m_mn[i] && ampm == m_ap[i]) begin
            sched = 1; ms = i;
          end
      man    = manualFeed && !m_prev_man;
      age    = n - m_start;
      busy_b = (age >= 1) && (age <= D + C);
      free   = !busy_b || (age == D + C && !m_pend);
      if (busy_b && age == D) m_count = (m_count + 1) % 65536;
      if (busy_b && age == D + C && m_pend) begin
        m_start = n; m_last_man = m_pend_man; m_pend = 0;
        if (!m_pend_man) m_last_slot = m_pend_slot;
      end
      if (sched || man) begin
        if (free) begin
          m_start = n; m_last_man = !sched;
          if (sched) m_last_slot = ms;
        end else if (!m_pend) begin
          m_pend = 1; m_pend_man = !sched; m_pend_slot = ms;
        end else begin
          m_ovr = 1;
        end
      end
      if (int'(cfgSlot) < NS) begin
        if (cfgWriteHour && cfgData >= 1 && cfgData <= 12) m_hr[cfgSlot] = int'(cfgData);
        if (cfgWriteMin && cfgData <= 59) m_mn[cfgSlot] = int'(cfgData);
        if (cfgWriteAmpm)   m_ap[cfgSlot] = cfgData[0];
        if (cfgWriteEnable) m_en[cfgSlot] = cfgData[0];
      end
      m_prev_min = int'(minute);
      m_prev_man = manualFeed;
    end
    age     = n - m_start;
    e_motor = (age >= 0) && (age < D);
    e_busy  = (age >= 0) && (age < D + C);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    n++;
    check("motorOn",    32'(motorOn),    32'(e_motor));
    check("busy",       32'(busy),       32'(e_busy));
    check("feedCount",  32'(feedCount),  32'(m_count));
    check("lastSlot",   32'(lastSlot),   32'(m_last_slot));
    check("lastManual", 32'(lastManual), 32'(m_last_man));
    check("overrun",    32'(overrun),    32'(m_ovr));
  endtask

  task automatic set_time(input int h, input int m, input int s, input bit ap);
    hour = 8'(h); minute = 8'(m); second = 8'(s); ampm = ap;
  endtask

  task automatic wr(input int slot, input logic [3:0] strobes, input int data);
    cfgSlot = SW'(slot);
    cfgData = 8'(data);
    {cfgWriteHour, cfgWriteMin, cfgWriteAmpm, cfgWriteEnable} = strobes;
    tick();
    {cfgWriteHour, cfgWriteMin, cfgWriteAmpm, cfgWriteEnable} = 4'b0000;
  endtask

  task automatic run(input int k, output int motor_cnt, output int busy_cnt);
    motor_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < k; i++) begin
      tick();
      motor_cnt += int'(motorOn);
      busy_cnt  += int'(busy);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int mc, bc;
    // Reset state at 7:29:59 PM.
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    check("rst_motorOn", 32'(motorOn), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_feedCount", 32'(feedCount), 0);
    check("rst_overrun", 32'(overrun), 0);

    // 1: slot 1 = 7:30 PM fires once the time rolls over.
    wr(1, W_HR, 7); wr(1, W_MN, 30); wr(1, W_AP, 1); wr(1, W_EN, 1);
    check("t1_idle_before", 32'(busy), 0);
    set_time(7, 30, 0, 1); tick();
    check("t1_motor_first", 32'(motorOn), 1);
    check("t1_lastSlot", 32'(lastSlot), 1);
    check("t1_lastManual", 32'(lastManual), 0);
    run(9, mc, bc);
    check("t1_motor_cycles", 32'(mc + 1), 4);
    check("t1_busy_cycles", 32'(bc + 1), 7);
    check("t1_feedCount", 32'(feedCount), 1);

    // 2: slots 0 and 2 both 8:00 AM; lowest index wins, single pulse.
    wr(0, W_HR, 8); wr(0, W_MN, 0); wr(0, W_AP, 0); wr(0, W_EN, 1);
    wr(2, W_HR, 8); wr(2, W_MN, 0); wr(2, W_AP, 0); wr(2, W_EN, 1);
    set_time(7, 59, 59, 0); tick();
    set_time(8, 0, 0, 0); tick();
    check("t2_lastSlot", 32'(lastSlot), 0);
    run(9, mc, bc);
    check("t2_motor_cycles", 32'(mc), 3);
    check("t2_feedCount", 32'(feedCount), 2);

    // 3: manual feed, then two more rising edges during DISPENSE.
    manualFeed = 1'b1; tick();
    check("t3_lastManual", 32'(lastManual), 1);
    manualFeed = 1'b0; tick();
    manualFeed = 1'b1; tick();
    check("t3_no_overrun_yet", 32'(overrun), 0);
    manualFeed = 1'b0; tick();
    manualFeed = 1'b1; tick();
    check("t3_overrun", 32'(overrun), 1);
    manualFeed = 1'b0;
    run(20, mc, bc);
    check("t3_queued_motor_cycles", 32'(mc), 4);
    check("t3_busy_cycles", 32'(bc), 9);
    check("t3_feedCount", 32'(feedCount), 4);
    check("t3_lastManual_queued", 32'(lastManual), 1);

    // 4: out-of-range hour/minute data and out-of-range slot index are ignored.
    set_time(11, 58, 0, 0);
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    wr(0, W_EN, 1); wr(0, W_HR, 13); wr(0, W_MN, 60);
    wr(3, W_HR, 11); wr(3, W_MN, 59); wr(3, W_AP, 0); wr(3, W_EN, 1);
    set_time(11, 59, 0, 0); tick();
    check("t4_slot3_ignored", 32'(busy), 0);
    set_time(12, 0, 0, 0); tick();
    check("t4_slot0_unchanged", 32'(motorOn), 1);
    check("t4_lastSlot", 32'(lastSlot), 0);
    run(9, mc, bc);

    // 5: no trigger on second != 0, unchanged minute, disabled slot, or same-cycle enable.
    wr(1, W_HR, 1); wr(1, W_MN, 5); wr(1, W_AP, 0); wr(1, W_EN, 1);
    set_time(1, 5, 17, 0); tick();
    check("t5_second_nonzero", 32'(busy), 0);
    set_time(1, 5, 0, 0); tick();
    check("t5_minute_unchanged", 32'(busy), 0);
    set_time(1, 4, 30, 0); tick();
    wr(1, W_EN, 0);
    set_time(1, 5, 0, 0); tick();
    check("t5_disabled", 32'(busy), 0);
    set_time(1, 4, 59, 0); tick();
    set_time(1, 5, 0, 0); wr(1, W_EN, 1);
    check("t5_same_cycle_enable", 32'(busy), 0);
    set_time(1, 4, 59, 0); tick();
    set_time(1, 5, 0, 0); wr(1, W_EN, 0);
    check("t5_same_cycle_disable", 32'(motorOn), 1);
    check("t5_lastSlot", 32'(lastSlot), 1);
    run(9, mc, bc);

    // 6: reset during the 2nd DISPENSE cycle with manualFeed held high.
    manualFeed = 1'b1; tick(); tick();
    check("t6_motor_before_reset", 32'(motorOn), 1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("t6_motor_after_reset", 32'(motorOn), 0);
    check("t6_feedCount", 32'(feedCount), 0);
    run(3, mc, bc);
    check("t6_held_manual_no_fire", 32'(bc), 0);
    set_time(11, 59, 0, 0); tick();
    set_time(12, 0, 0, 0); tick();
    check("t6_enables_cleared", 32'(busy), 0);
    manualFeed = 1'b0; tick();

    // Random traffic: time jumps over a small range so slots match often.
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 5) == 0) manualFeed = ~manualFeed;
      if ($urandom_range(0, 2) == 0)
        set_time(int'($urandom_range(1, 2)), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 59)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        cfgSlot = SW'($urandom_range(0, 3));
        cfgData = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 14));
        {cfgWriteHour, cfgWriteMin, cfgWriteAmpm, cfgWriteEnable} = 4'($urandom);
      end else begin
        {cfgWriteHour, cfgWriteMin, cfgWriteAmpm, cfgWriteEnable} = 4'b0000;
      end
      tick();
    end
    reset = 1'b0;
    {cfgWriteHour, cfgWriteMin, cfgWriteAmpm, cfgWriteEnable} = 4'b0000;
    run(12, mc, bc);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
